// File: rtl/fpu_minmax_reduce_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg -- shared definitions for the floating-point min/max reducer.
//   * default field widths (exponent, fraction, element index)
//   * MODE_MAX / MODE_MIN encodings of the mode input
//   * state_t: reducer FSM states
//   * canon_qnan(): canonical quiet-NaN bit pattern for a given format
// ----------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int FRAC_W_DEF = 23;
    localparam int IDX_W_DEF  = 8;

    localparam logic MODE_MAX = 1'b1;
    localparam logic MODE_MIN = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,   // no vector open
        ACCUM = 1'b1    // vector open, accumulating
    } state_t;

    // Sign 1, exponent all ones, fraction MSB 1, rest 0. Built as a run of
    // (exp_w + 2) ones placed so that it ends at the fraction MSB.
    // Formats up to 64 bits wide are supported.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int frac_w);
        logic [63:0] ones;
        ones = (64'd1 << (exp_w + 2)) - 64'd1;
        return ones << (frac_w - 1);
    endfunction

endpackage

// File: rtl/fpu_minmax_cmp.sv
// ----------------------------------------------------------------------------
// fpu_minmax_cmp -- combinational two-operand ordering for min/max reduction.
// Ports:
//   a      in  W   current accumulator value
//   b      in  W   candidate value
//   mode   in  1   MODE_MAX: b wins if strictly greater; MODE_MIN: if smaller
//   b_wins out 1   b strictly beats a (meaningless when either is NaN)
//   a_nan  out 1   a is a NaN (exp all ones, frac nonzero)
//   b_nan  out 1   b is a NaN
// ----------------------------------------------------------------------------
module fpu_minmax_cmp
    import fpu_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    input  logic                  mode,
    output logic                  b_wins,
    output logic                  a_nan,
    output logic                  b_nan
);

    localparam int W = 1 + EXP_W + FRAC_W;

    logic [W-1:0] w_key_a;
    logic [W-1:0] w_key_b;

    assign a_nan = (&a[W-2 -: EXP_W]) && (|a[FRAC_W-1:0]);
    assign b_nan = (&b[W-2 -: EXP_W]) && (|b[FRAC_W-1:0]);

    // Map sign-magnitude onto a monotonic unsigned key: positives sit above
    // all negatives, and negative magnitudes are inverted so larger magnitude
    // means smaller value. -0 maps just below +0, infinities to the extremes.
    assign w_key_a = a[W-1] ? {1'b0, ~a[W-2:0]} : {1'b1, a[W-2:0]};
    assign w_key_b = b[W-1] ? {1'b0, ~b[W-2:0]} : {1'b1, b[W-2:0]};

    // Strict comparison: ties leave the earlier element in place.
    assign b_wins = (mode == MODE_MAX) ? (w_key_b > w_key_a) : (w_key_b < w_key_a);

endmodule

// File: rtl/fpu_minmax_reduce.sv
// ----------------------------------------------------------------------------
// fpu_minmax_reduce -- streaming fmin/fmax reduction over a vector of floats,
// reporting the winning value and its 0-based position.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode                1 = fmax, 0 = fmin; captured with a vector's first element
//   in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_data [W]         {sign, exp, frac}
//   in_last             final element of the vector
//   out_valid/out_ready result handshake; result registered one cycle after
//                       the last element is accepted
//   out_data [W]        min/max (canonical qNaN if any element was NaN)
//   out_index [IDX_W]   position of the winner / first NaN (wraps mod 2^IDX_W)
//   out_nan             vector contained a NaN
// Build option: define FPU_MINMAX_DAZ_EN to flush subnormal inputs to signed
// zero before comparison and storage.
// ----------------------------------------------------------------------------
module fpu_minmax_reduce
    import fpu_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_nan
);

    localparam int              W         = 1 + EXP_W + FRAC_W;
    localparam logic [63:0]     QNAN_FULL = canon_qnan(EXP_W, FRAC_W);
    localparam logic [W-1:0]    QNAN      = QNAN_FULL[W-1:0];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_acc;
    logic [IDX_W-1:0] r_acc_idx;
    logic [IDX_W-1:0] r_cnt;        // index of the most recently accepted element
    logic             r_nan;
    logic             r_mode;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [IDX_W-1:0] r_out_index;
    logic             r_out_nan;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_first;
    logic [W-1:0]     w_in_eff;
    logic [IDX_W-1:0] w_elem_idx;
    logic             w_b_wins;
    logic             w_a_nan;
    logic             w_b_nan;
    logic [W-1:0]     w_acc_nxt;
    logic [IDX_W-1:0] w_acc_idx_nxt;
    logic             w_nan_nxt;
    logic             w_mode_nxt;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_first    = (r_state == IDLE);

`ifdef FPU_MINMAX_DAZ_EN
    // Exponent zero covers both true zeros and subnormals; either becomes a
    // signed zero.
    assign w_in_eff = (in_data[W-2 -: EXP_W] == '0) ? {in_data[W-1], {(W-1){1'b0}}}
                                                    : in_data;
`else
    assign w_in_eff = in_data;
`endif

    fpu_minmax_cmp #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_cmp (
        .a      (r_acc),
        .b      (w_in_eff),
        .mode   (r_mode),
        .b_wins (w_b_wins),
        .a_nan  (w_a_nan),
        .b_nan  (w_b_nan)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path
        // leaves it unassigned, which would infer a latch.
        w_state_nxt = r_state;
        if (w_in_fire) begin
            w_state_nxt = in_last ? IDLE : ACCUM;
        end
    end

    // Accumulator update for the element currently on the input.
    always_comb begin
        w_elem_idx    = w_first ? '0 : r_cnt + 1'b1;
        w_acc_nxt     = r_acc;
        w_acc_idx_nxt = r_acc_idx;
        w_nan_nxt     = r_nan;
        w_mode_nxt    = r_mode;
        if (w_first) begin
            w_acc_nxt     = w_in_eff;
            w_acc_idx_nxt = '0;
            w_nan_nxt     = w_b_nan;
            w_mode_nxt    = mode;
        end else if (!(r_nan || w_a_nan)) begin
            // Once a NaN is seen the result is fixed; only the first NaN's
            // position is kept.
            if (w_b_nan) begin
                w_acc_nxt     = w_in_eff;
                w_acc_idx_nxt = w_elem_idx;
                w_nan_nxt     = 1'b1;
            end else if (w_b_wins) begin
                w_acc_nxt     = w_in_eff;
                w_acc_idx_nxt = w_elem_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_idx   <= '0;
            r_cnt       <= '0;
            r_nan       <= 1'b0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_nan   <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_acc     <= w_acc_nxt;
                r_acc_idx <= w_acc_idx_nxt;
                r_cnt     <= w_elem_idx;
                r_nan     <= w_nan_nxt;
                r_mode    <= w_mode_nxt;
            end
            // A last element is only accepted when the output slot is free or
            // draining this cycle, so loading here never overwrites a held result.
            if (w_in_fire && in_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_nan_nxt ? QNAN : w_acc_nxt;
                r_out_index <= w_acc_idx_nxt;
                r_out_nan   <= w_nan_nxt;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_nan   = r_out_nan;

endmodule

// File: tb/tb_fpu_minmax_reduce.sv
// ----------------------------------------------------------------------------
// tb_fpu_minmax_reduce -- directed self-checking bench for fpu_minmax_reduce
// at default widths (32-bit floats, 8-bit index).
// ----------------------------------------------------------------------------
module tb_fpu_minmax_reduce;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_index;
    logic        out_nan;

    int n_pass;
    int n_total;

    fpu_minmax_reduce dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one element for one clock; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic last, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== 42'd0)
            $display("FAIL reset_outputs: got %h want 0", {out_valid, out_nan, out_index, out_data});
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fmax_basic();
        send(32'h3F800000, 1'b0, 1'b1);
        send(32'hC0000000, 1'b0, 1'b1);
        send(32'h40400000, 1'b0, 1'b1);
        send(32'h3F000000, 1'b1, 1'b1);
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== {1'b1, 1'b0, 8'd2, 32'h40400000})
            $display("FAIL fmax_basic: got v=%b n=%b i=%0d d=%h want v=1 n=0 i=2 d=40400000",
                     out_valid, out_nan, out_index, out_data);
        else n_pass++;
        consume();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL valid_clear: got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_signed_zero();
        send(32'h00000000, 1'b0, 1'b0);
        send(32'h80000000, 1'b1, 1'b0);
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== {1'b1, 1'b0, 8'd1, 32'h80000000})
            $display("FAIL fmin_zero: got i=%0d d=%h want i=1 d=80000000", out_index, out_data);
        else n_pass++;
        consume();
        send(32'h00000000, 1'b0, 1'b1);
        send(32'h80000000, 1'b1, 1'b1);
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== {1'b1, 1'b0, 8'd0, 32'h00000000})
            $display("FAIL fmax_zero: got i=%0d d=%h want i=0 d=00000000", out_index, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_nan();
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h7FC00001, 1'b0, 1'b0);
        send(32'hFF800000, 1'b1, 1'b0);
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== {1'b1, 1'b1, 8'd1, 32'hFFC00000})
            $display("FAIL nan_sticky: got n=%b i=%0d d=%h want n=1 i=1 d=ffc00000",
                     out_nan, out_index, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_ordering();
        // Equal values: the earlier element keeps the win.
        send(32'h40000000, 1'b0, 1'b1);
        send(32'h40000000, 1'b1, 1'b1);
        n_total++;
        if ({out_index, out_data} !== {8'd0, 32'h40000000})
            $display("FAIL tie_keeps_first: got i=%0d d=%h want i=0 d=40000000", out_index, out_data);
        else n_pass++;
        consume();
        // Negatives: -1 is greater than -2.
        send(32'hBF800000, 1'b0, 1'b1);
        send(32'hC0000000, 1'b1, 1'b1);
        n_total++;
        if ({out_index, out_data} !== {8'd0, 32'hBF800000})
            $display("FAIL fmax_neg: got i=%0d d=%h want i=0 d=bf800000", out_index, out_data);
        else n_pass++;
        consume();
        send(32'hBF800000, 1'b0, 1'b0);
        send(32'hC0000000, 1'b1, 1'b0);
        n_total++;
        if ({out_index, out_data} !== {8'd1, 32'hC0000000})
            $display("FAIL fmin_neg: got i=%0d d=%h want i=1 d=c0000000", out_index, out_data);
        else n_pass++;
        consume();
        // Infinities are ordinary extremes.
        send(32'h7F7FFFFF, 1'b0, 1'b0);
        send(32'hFF800000, 1'b1, 1'b0);
        n_total++;
        if ({out_nan, out_index, out_data} !== {1'b0, 8'd1, 32'hFF800000})
            $display("FAIL fmin_neg_inf: got n=%b i=%0d d=%h want n=0 i=1 d=ff800000",
                     out_nan, out_index, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_mode_latched();
        // fmin chosen on the first element; later mode=1 must be ignored.
        send(32'h40000000, 1'b0, 1'b0);
        send(32'h40400000, 1'b0, 1'b1);
        send(32'h3F800000, 1'b1, 1'b1);
        n_total++;
        if ({out_index, out_data} !== {8'd2, 32'h3F800000})
            $display("FAIL mode_latched: got i=%0d d=%h want i=2 d=3f800000", out_index, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_backpressure();
        send(32'h3F800000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({out_valid, out_nan, out_index, out_data, in_ready} !==
                {1'b1, 1'b0, 8'd0, 32'h3F800000, 1'b0})
                $display("FAIL hold_cycle%0d: got v=%b d=%h i=%0d rdy=%b want v=1 d=3f800000 i=0 rdy=0",
                         i, out_valid, out_data, out_index, in_ready);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        // Drain and refill in the same cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h41200000;
        in_last   = 1'b1;
        mode      = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL ready_on_drain: got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== {1'b1, 1'b0, 8'd0, 32'h41200000})
            $display("FAIL back_to_back: got v=%b i=%0d d=%h want v=1 i=0 d=41200000",
                     out_valid, out_index, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_reset_mid();
        // Result held when reset hits: outputs must clear without a clock edge.
        send(32'h40400000, 1'b1, 1'b1);
        rst_n = 1'b0;
        #2;
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== 42'd0)
            $display("FAIL async_reset_outputs: got %h want 0", {out_valid, out_nan, out_index, out_data});
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Open a vector containing a NaN, then abandon it by reset.
        send(32'h7FC00000, 1'b0, 1'b1);
        send(32'h3F800000, 1'b0, 1'b1);
        send(32'h40000000, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== 42'd0)
            $display("FAIL midvec_reset_outputs: got %h want 0", {out_valid, out_nan, out_index, out_data});
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'h40000000, 1'b1, 1'b0);
        n_total++;
        if ({out_valid, out_nan, out_index, out_data} !== {1'b1, 1'b0, 8'd0, 32'h40000000})
            $display("FAIL after_reset_vector: got v=%b n=%b i=%0d d=%h want v=1 n=0 i=0 d=40000000",
                     out_valid, out_nan, out_index, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_index_wrap();
        // 258 elements; the winner sits at position 257, which wraps to 1.
        for (int i = 0; i < 257; i++) send(32'h3F800000, 1'b0, 1'b1);
        send(32'h40000000, 1'b1, 1'b1);
        n_total++;
        if ({out_index, out_data} !== {8'd1, 32'h40000000})
            $display("FAIL index_wrap: got i=%0d d=%h want i=1 d=40000000", out_index, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_subnormal();
`ifdef FPU_MINMAX_DAZ_EN
        send(32'h80000001, 1'b0, 1'b1);
        send(32'h00000000, 1'b1, 1'b1);
        n_total++;
        if ({out_index, out_data} !== {8'd1, 32'h00000000})
            $display("FAIL daz_fmax: got i=%0d d=%h want i=1 d=00000000", out_index, out_data);
        else n_pass++;
`else
        send(32'h80000001, 1'b0, 1'b0);
        send(32'h00000000, 1'b1, 1'b0);
        n_total++;
        if ({out_index, out_data} !== {8'd0, 32'h80000001})
            $display("FAIL subnormal_fmin: got i=%0d d=%h want i=0 d=80000001", out_index, out_data);
        else n_pass++;
`endif
        consume();
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_fmax_basic();
        test_signed_zero();
        test_nan();
        test_ordering();
        test_mode_latched();
        test_backpressure();
        test_reset_mid();
        test_index_wrap();
        test_subnormal();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
